// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execute stage.
// Holds the ALU control codes (same encoding the ALU controller drives),
// the execute FSM state encoding and default datapath sizes.
package alu_exec_unit_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int SHAMT_W_DEF = 3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_CMP = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Shift codes take the bit-serial path; everything else completes in EXEC.
  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issuing stage and the ALU execute unit.
// master drives the request side (start, code, operands); slave drives status/result.
// Clock and reset are kept outside the bundle.
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] rs;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             illegal;

  modport master (
    output start, alu_ctrl, rd, rs,
    input  busy, done, result, zero_flag, carry_flag, illegal
  );

  modport slave (
    input  start, alu_ctrl, rd, rs,
    output busy, done, result, zero_flag, carry_flag, illegal
  );

endinterface

// File: rtl/alu_exec_unit_serial_shifter.sv
// Bit-serial shifter: moves the working register one position per step.
// Latency: amount steps after load; cnt_zero flags completion.
// No backpressure: load overrides any shift in progress, step is a no-op once done.
module alu_serial_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               dir_left,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] amount,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out,
  output logic               cnt_zero
);

  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               left_q, left_d;
  logic               carry_q, carry_d;

  // Next state: load captures operand/amount, each step shifts once and counts down.
  always_comb begin
    cnt_d   = cnt_q;
    work_d  = work_q;
    left_d  = left_q;
    carry_d = carry_q;
    if (load) begin
      cnt_d   = amount;
      work_d  = data_in;
      left_d  = dir_left;
      carry_d = 1'b0;          // a zero-length shift reports no bit shifted out
    end else if (step && (cnt_q != '0)) begin
      if (left_q) begin
        carry_d = work_q[WIDTH-1];
        work_d  = {work_q[WIDTH-2:0], 1'b0};
      end else begin
        carry_d = work_q[0];
        work_d  = {1'b0, work_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      work_q  <= '0;
      left_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      left_q  <= left_d;
      carry_q <= carry_d;
    end
  end

  assign data_out  = work_q;
  assign carry_out = carry_q;
  assign cnt_zero  = (cnt_q == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: latches code + operands on start, returns registered result/flags with a done pulse.
// Latency: 1 cycle for non-shift codes, amount+1 cycles for SLL/SRL (acceptance edge to done edge).
// start is only accepted while idle (busy=0); requests while busy are ignored, never queued.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  alu_exec_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             shf_load;
  logic             shf_step;
  logic [WIDTH-1:0] shf_data;
  logic             shf_carry;
  logic             shf_cnt_zero;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;

  assign accept   = bus.start && (state_q == IDLE);
  assign shf_load = accept && is_shift_op(bus.alu_ctrl);
  assign shf_step = (state_q == SHIFT);

  // Extra top bit gives the carry (ADD) or the borrow (SUB/CMP).
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (shf_load),
    .step      (shf_step),
    .dir_left  (bus.alu_ctrl == ALU_SLL),
    .data_in   (bus.rd),
    .amount    (bus.rs[SHAMT_W-1:0]),
    .data_out  (shf_data),
    .carry_out (shf_carry),
    .cnt_zero  (shf_cnt_zero)
  );

  // FSM next state and datapath: capture in IDLE, compute in EXEC, wait out the shifter in SHIFT.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.alu_ctrl;
          a_d     = bus.rd;
          b_d     = bus.rs;
          busy_d  = 1'b1;
          state_d = is_shift_op(bus.alu_ctrl) ? SHIFT : EXEC;
        end
      end
      EXEC: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        case (op_q)
          ALU_ADD: begin
            result_d = sum_w[WIDTH-1:0];
            carry_d  = sum_w[WIDTH];
            zero_d   = (sum_w[WIDTH-1:0] == '0);
          end
          ALU_SUB: begin
            result_d = diff_w[WIDTH-1:0];
            carry_d  = diff_w[WIDTH];
            zero_d   = (diff_w[WIDTH-1:0] == '0);
          end
          ALU_AND: begin
            result_d = a_q & b_q;
            carry_d  = 1'b0;
            zero_d   = ((a_q & b_q) == '0);
          end
          ALU_OR: begin
            result_d = a_q | b_q;
            carry_d  = 1'b0;
            zero_d   = ((a_q | b_q) == '0);
          end
          ALU_NOT: begin
            result_d = ~a_q;
            carry_d  = 1'b0;
            zero_d   = (~a_q == '0);
          end
          ALU_CMP: begin
            // Flags only; zero reports rd==rs while the result register is left alone.
            carry_d = diff_w[WIDTH];
            zero_d  = (diff_w[WIDTH-1:0] == '0);
          end
          default: begin
            // Codes 8..15 (shift codes never reach EXEC): keep result/flags, flag illegal.
            illegal_d = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        if (shf_cnt_zero) begin
          result_d = shf_data;
          carry_d  = shf_carry;
          zero_d   = (shf_data == '0);
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and output registers; reset aborts any operation in flight without a done.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: fixed vector table, handshake/reset sequences, random ops vs a reference model.
module tb_alu_exec_unit;

  logic clock = 1'b0;
  logic reset_n;

  alu_exec_unit_if #(.WIDTH(8)) bus ();

  alu_exec_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  int done_cnt = 0;

  // Count done pulses (pre-edge value of done at each rising edge).
  always @(posedge clock) if (bus.done) done_cnt <= done_cnt + 1;

  // Reference model state: architectural result/flags after the last completed op.
  logic [7:0] m_res;
  logic       m_z, m_c, m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: what one operation does to result/flags, plus its latency.
  task automatic model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, output int lat);
    int s;
    int n;
    logic [15:0] w;
    lat   = 1;
    m_ill = 1'b0;
    n     = int'(b) % 8;
    case (c)
      4'd0: begin s = int'(a) + int'(b); m_res = s[7:0]; m_c = (s > 255); m_z = (m_res == 8'h00); end
      4'd1: begin s = int'(a) - int'(b); m_res = s[7:0]; m_c = (a < b);   m_z = (m_res == 8'h00); end
      4'd2: begin m_res = a & b; m_c = 1'b0; m_z = (m_res == 8'h00); end
      4'd3: begin m_res = a | b; m_c = 1'b0; m_z = (m_res == 8'h00); end
      4'd4: begin m_res = ~a;    m_c = 1'b0; m_z = (m_res == 8'h00); end
      4'd5: begin
        w = {8'h00, a} << n; m_res = w[7:0]; m_c = (n != 0) && w[8]; m_z = (m_res == 8'h00); lat = n + 1;
      end
      4'd6: begin
        w = {a, 8'h00} >> n; m_res = w[15:8]; m_c = (n != 0) && w[7]; m_z = (m_res == 8'h00); lat = n + 1;
      end
      4'd7: begin m_c = (a < b); m_z = (a == b); end
      default: m_ill = 1'b1;
    endcase
  endtask

  // Issue one op at the current negedge (DUT must be idle) and wait for its done.
  // hold=1 keeps start high and scrambles the inputs while busy; they must be ignored.
  task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, input bit hold,
                       output logic [7:0] o_res, output logic o_z, output logic o_c,
                       output logic o_ill, output int lat);
    bit seen;
    chk("idle_before_start", bus.busy, 1'b0);
    bus.start = 1'b1; bus.alu_ctrl = c; bus.rd = a; bus.rs = b;
    @(posedge clock);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clock);
      if (lat == 0) begin
        if (!hold) bus.start = 1'b0;
        else begin bus.alu_ctrl = ~c; bus.rd = ~a; bus.rs = b ^ 8'h5A; end
      end
      if (lat > 0 && bus.done) seen = 1;
      else begin
        chk("busy_in_flight", bus.busy, 1'b1);
        chk("done_in_flight", bus.done, 1'b0);
        @(posedge clock);
        lat++;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("busy_at_done", bus.busy, 1'b0);
    o_res = bus.result; o_z = bus.zero_flag; o_c = bus.carry_flag; o_ill = bus.illegal;
  endtask

  typedef struct {
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       cy;
    logic       ill;
    int         lat;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    logic [7:0] r;
    logic z, cy, il;
    int lat, mlat, d0;
    logic [3:0] c;
    logic [7:0] a, b;

    // Applied back-to-back: each op is issued in the done cycle of the previous one.
    tbl[0]  = '{4'h0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1};  // ADD with carry out
    tbl[1]  = '{4'h1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1};  // SUB to zero
    tbl[2]  = '{4'h7, 8'h03, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1};  // CMP keeps result
    tbl[3]  = '{4'h5, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4};  // SLL by 3
    tbl[4]  = '{4'h6, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 2};  // SRL shifts out the 1
    tbl[5]  = '{4'h5, 8'hAA, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, 1};  // shift by 0
    tbl[6]  = '{4'hA, 8'h12, 8'h34, 8'hAA, 1'b0, 1'b0, 1'b1, 1};  // illegal, state kept
    tbl[7]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1};  // AND
    tbl[8]  = '{4'h3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};  // OR to zero
    tbl[9]  = '{4'h4, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0, 1'b0, 1};  // NOT
    tbl[10] = '{4'h1, 8'h03, 8'h07, 8'hFC, 1'b0, 1'b1, 1'b0, 1};  // SUB with borrow
    tbl[11] = '{4'h6, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8};  // SRL by 7, upper rs bits ignored
    tbl[12] = '{4'h5, 8'hFF, 8'h07, 8'h80, 1'b0, 1'b1, 1'b0, 8};  // SLL by 7
    tbl[13] = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1};  // ADD wraps to zero
    tbl[14] = '{4'hF, 8'h55, 8'h66, 8'h00, 1'b1, 1'b1, 1'b1, 1};  // illegal keeps set flags

    // Reset
    reset_n = 1'b0;
    bus.start = 1'b0; bus.alu_ctrl = 4'h0; bus.rd = 8'h00; bus.rs = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_result", bus.result, 8'h00);
    chk("rst_zero", bus.zero_flag, 1'b0);
    chk("rst_carry", bus.carry_flag, 1'b0);
    reset_n = 1'b1;
    m_res = 8'h00; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0;
    @(negedge clock);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      model(tbl[i].c, tbl[i].a, tbl[i].b, mlat);
      issue(tbl[i].c, tbl[i].a, tbl[i].b, 1'b0, r, z, cy, il, lat);
      chk($sformatf("v%0d_result", i), r, tbl[i].res);
      chk($sformatf("v%0d_zero", i), z, tbl[i].z);
      chk($sformatf("v%0d_carry", i), cy, tbl[i].cy);
      chk($sformatf("v%0d_illegal", i), il, tbl[i].ill);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
    end

    // start held high through an SRL by 5 with changing inputs: exactly one done
    @(negedge clock);
    d0 = done_cnt;
    model(4'h6, 8'hB4, 8'h05, mlat);
    issue(4'h6, 8'hB4, 8'h05, 1'b1, r, z, cy, il, lat);
    chk("hold_result", r, 8'h05);
    chk("hold_carry", cy, 1'b1);
    chk("hold_latency", lat, 6);
    repeat (8) @(negedge clock);
    chk("hold_done_count", done_cnt - d0, 1);
    chk("hold_idle_after", bus.busy, 1'b0);

    // Random operations against the model, with occasional idle gaps
    for (int i = 0; i < 250; i++) begin
      int k;
      k = $urandom_range(0, 9);
      c = (k < 8) ? 4'(k) : 4'($urandom_range(8, 15));
      a = 8'($urandom); b = 8'($urandom);
      model(c, a, b, mlat);
      issue(c, a, b, ($urandom_range(0, 4) == 0), r, z, cy, il, lat);
      chk("rnd_result", r, m_res);
      chk("rnd_zero", z, m_z);
      chk("rnd_carry", cy, m_c);
      chk("rnd_illegal", il, m_ill);
      chk("rnd_latency", lat, mlat);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        chk("rnd_done_pulse_width", bus.done, 1'b0);
        chk("rnd_illegal_pulse_width", bus.illegal, 1'b0);
      end
    end

    // Reset during an SLL by 7 aborts it with no done
    model(4'h0, 8'h40, 8'h02, mlat);
    issue(4'h0, 8'h40, 8'h02, 1'b0, r, z, cy, il, lat);
    chk("pre_abort_result", r, 8'h42);
    bus.start = 1'b1; bus.alu_ctrl = 4'h5; bus.rd = 8'h81; bus.rs = 8'h07;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_busy_before", bus.busy, 1'b1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = done_cnt;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_result", bus.result, 8'h00);
    chk("abort_zero", bus.zero_flag, 1'b0);
    chk("abort_carry", bus.carry_flag, 1'b0);
    repeat (10) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);
    m_res = 8'h00; m_z = 1'b0; m_c = 1'b0;
    model(4'h0, 8'h01, 8'h01, mlat);
    issue(4'h0, 8'h01, 8'h01, 1'b0, r, z, cy, il, lat);
    chk("post_abort_result", r, 8'h02);
    chk("post_abort_zero", z, 1'b0);
    chk("post_abort_carry", cy, 1'b0);
    chk("post_abort_latency", lat, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
